// File: rtl/sel_scan_pkg.sv
// Shared types, default sizes and the lowest-set-channel helper for the select scanner.
package sel_scan_pkg;

    localparam int NCH_DEF   = 5;
    localparam int SEL_W_DEF = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

    // Lowest set bit of a mask of up to eight channels; 0 when the mask is empty.
    function automatic logic [SEL_W_DEF-1:0] first_set(input logic [7:0] mask);
        logic [SEL_W_DEF-1:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sel_scan_5ch_chk.sv
// Runtime checks for the select scanner: the select must never leave the channel range.
module sel_scan_5ch_chk #(
    parameter int NCH   = 5,
    parameter int SEL_W = 3
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic [SEL_W-1:0] s_i
);

    localparam logic [SEL_W:0] NCH_W = (SEL_W + 1)'(NCH);

    // Select code must always address a real mux input.
    a_sel_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, s_i} < NCH_W))
        else $error("select out of range: %0d", s_i);

endmodule

// File: rtl/sel_scan_5ch_next_chan_finder.sv
// Circular priority encoder: finds the next enabled channel strictly after cur_i.
module next_chan_finder
    import sel_scan_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [NCH-1:0]   mask_i,
    input  logic [SEL_W-1:0] cur_i,
    output logic [SEL_W-1:0] nxt_o,
    output logic             found_o,
    output logic             wrapped_o
);

    // Walk offsets from far to near so the nearest enabled channel wins; offset NCH is cur itself.
    always_comb begin
        int c;
        nxt_o     = cur_i;
        found_o   = 1'b0;
        wrapped_o = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            c = int'(cur_i) + i;
            if (c >= NCH) begin
                c = c - NCH;
            end else begin
                c = c;
            end
            if ((c < NCH) && mask_i[c]) begin
                nxt_o     = SEL_W'(c);
                found_o   = 1'b1;
                wrapped_o = (c <= int'(cur_i));
            end else begin
                found_o   = found_o;
            end
        end
    end

endmodule

// File: rtl/sel_scan_5ch.sv
// Round-robin mux select sequencer with per-channel mask and programmable dwell.
// Optional override port pair enabled by defining SCAN_FORCE_EN.
module sel_scan_5ch
    import sel_scan_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
`ifdef SCAN_FORCE_EN
    input  logic               force_valid_i,
    input  logic [SEL_W-1:0]   force_sel_i,
`endif
    input  logic               en_i,
    input  logic [NCH-1:0]     mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [SEL_W-1:0]   s_o,
    output logic               s_valid_o,
    output logic               wrap_o
);

    localparam logic [SEL_W:0] NCH_W = (SEL_W + 1)'(NCH);

    scan_state_t        state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   nxt_s;
    logic               found_s;
    logic               wrapped_s;
    logic               run_ok_s;
`ifdef SCAN_FORCE_EN
    logic               forced_q, forced_d;
    logic               force_req_s;
`endif

    next_chan_finder #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_finder (
        .mask_i    (mask_i),
        .cur_i     (s_q),
        .nxt_o     (nxt_s),
        .found_o   (found_s),
        .wrapped_o (wrapped_s)
    );

    // found_s doubles as "mask has at least one channel set".
    assign run_ok_s = en_i && found_s;
`ifdef SCAN_FORCE_EN
    assign force_req_s = force_valid_i && ({1'b0, force_sel_i} < NCH_W);
`endif

    // Next-state and output decisions.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef SCAN_FORCE_EN
        forced_d = forced_q;
        if (force_req_s) begin
            s_d      = force_sel_i;
            valid_d  = 1'b1;
            forced_d = 1'b1;
        end else if (forced_q) begin
            forced_d = 1'b0;
            if (run_ok_s) begin
                state_d = ST_RUN;
                s_d     = nxt_s;
                cnt_d   = dwell_i;
                valid_d = 1'b1;
                wrap_d  = wrapped_s;
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        end else begin
`endif
        case (state_q)
            ST_IDLE: begin
                if (run_ok_s) begin
                    state_d = ST_RUN;
                    s_d     = SEL_W'(first_set(8'(mask_i)));
                    valid_d = 1'b1;
                    cnt_d   = dwell_i;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                // Losing enable beats a pending advance; clearing the live bit cuts the dwell.
                if (!run_ok_s) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if ((cnt_q != {DWELL_W{1'b0}}) && mask_i[s_q]) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    s_d     = nxt_s;
                    cnt_d   = dwell_i;
                    valid_d = 1'b1;
                    wrap_d  = wrapped_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
`ifdef SCAN_FORCE_EN
        end
`endif
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            s_q     <= {SEL_W{1'b0}};
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= {DWELL_W{1'b0}};
`ifdef SCAN_FORCE_EN
            forced_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
`ifdef SCAN_FORCE_EN
            forced_q <= forced_d;
`endif
        end
    end

    assign s_o       = s_q;
    assign s_valid_o = valid_q;
    assign wrap_o    = wrap_q;

    sel_scan_5ch_chk #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .s_i    (s_q)
    );

endmodule

// File: tb/tb_sel_scan_5ch.sv
// Self-checking bench for sel_scan_5ch: directed vector table, corner sequences, random vs model.
module tb_sel_scan_5ch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] mask;
    logic [7:0] dwell;
    logic [2:0] s;
    logic       sv;
    logic       wr;
`ifdef SCAN_FORCE_EN
    logic       fv;
    logic [2:0] fs;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sel_scan_5ch dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
`ifdef SCAN_FORCE_EN
        .force_valid_i (fv),
        .force_sel_i   (fs),
`endif
        .en_i          (en),
        .mask_i        (mask),
        .dwell_i       (dwell),
        .s_o           (s),
        .s_valid_o     (sv),
        .wrap_o        (wr)
    );

    typedef struct {
        logic       en;
        logic [4:0] mask;
        logic [7:0] dwell;
        logic [2:0] s;
        logic       v;
        logic       w;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: which channel is live and how many hold cycles remain on it.
    logic       m_act;
    logic [2:0] m_s;
    int         m_left;
    logic       m_v;
    logic       m_w;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int es, input int ev, input int ew);
        chk({name, ".s"}, int'(s), es);
        chk({name, ".valid"}, int'(sv), ev);
        chk({name, ".wrap"}, int'(wr), ew);
    endtask

    function automatic vec_t mk(input logic e, input logic [4:0] m, input logic [7:0] d,
                                input logic [2:0] es, input logic ev, input logic ew);
        vec_t r;
        r.en = e; r.mask = m; r.dwell = d; r.s = es; r.v = ev; r.w = ew;
        return r;
    endfunction

    function automatic logic [2:0] lowest(input logic [4:0] m);
        for (int i = 0; i < 5; i++) if (m[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [2:0] next_after(input logic [4:0] m, input logic [2:0] cur);
        for (int k = 1; k <= 5; k++) begin
            int idx;
            idx = (int'(cur) + k) % 5;
            if (m[idx]) return 3'(idx);
        end
        return cur;
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_s = 3'd0; m_left = 0; m_v = 1'b0; m_w = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [4:0] m, input int dw);
        logic [2:0] n;
        m_w = 1'b0;
        if (!e || m == 5'd0) begin
            m_act = 1'b0;
            m_v   = 1'b0;
        end else if (!m_act) begin
            m_act  = 1'b1;
            m_v    = 1'b1;
            m_s    = lowest(m);
            m_left = dw;
        end else if (m_left > 0 && m[m_s]) begin
            m_left = m_left - 1;
        end else begin
            n      = next_after(m, m_s);
            m_w    = (n <= m_s);
            m_s    = n;
            m_left = dw;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mask = 5'd0; dwell = 8'd0;
`ifdef SCAN_FORCE_EN
        fv = 1'b0; fs = 3'd0;
`endif
        #12;
        chk_out("reset0", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_out("idle_after_reset", 0, 0, 0);

        // Build S=3 with cnt=5, then reset asynchronously between edges.
        en = 1'b1; mask = 5'b11111; dwell = 8'd0;
        tick(); tick(); tick();
        dwell = 8'd5;
        tick();
        chk_out("pre_reset_s3", 3, 1, 0);
        tick();
        chk_out("pre_reset_hold", 3, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("idle_en0", 0, 0, 0);
        end

        // Directed vector table: full scan, sparse mask with dwell, single channel, mask drop.
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 5'h1F, 8'd0, 3'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1F, 8'd0, 3'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h12, 8'd2, 3'd1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 5'h12, 8'd2, 3'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 8'd1, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 8'd1, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 8'd1, 3'd2, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 5'h04, 8'd1, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 8'd1, 3'd2, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 5'h00, 8'd1, 3'd2, 1'b0, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; mask = vecs[i].mask; dwell = vecs[i].dwell;
            tick();
            chk_out($sformatf("vec%0d", i), int'(vecs[i].s), int'(vecs[i].v), int'(vecs[i].w));
        end

        // Dwell cut: clear the live channel's bit mid-dwell, then drop EN on an advance cycle.
        en = 1'b1; mask = 5'b11111; dwell = 8'd0;
        tick();
        chk_out("cut_start", 0, 1, 0);
        dwell = 8'd9;
        tick();
        chk_out("cut_s1", 1, 1, 0);
        tick();
        chk_out("cut_s1_hold", 1, 1, 0);
        mask = 5'b11101;
        tick();
        chk_out("cut_jump", 2, 1, 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out($sformatf("cut_dwell%0d", i), 2, 1, 0);
        end
        en = 1'b0;
        tick();
        chk_out("en_beats_advance", 2, 0, 0);

        // Randomised run against the reference model.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        en = 1'b0; mask = 5'd0; dwell = 8'd0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) en = 1'b0;
            else en = 1'b1;
            if ($urandom_range(0, 7) == 0) mask = 5'($urandom);
            dwell = 8'($urandom_range(0, 3));
            tick();
            model_step(en, mask, int'(dwell));
            chk_out($sformatf("rand%0d", c), int'(m_s), int'(m_v), int'(m_w));
        end

`ifdef SCAN_FORCE_EN
        // Override: out-of-range request ignored, forced channel held, release resumes after it.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        en = 1'b1; mask = 5'b11111; dwell = 8'd0;
        fv = 1'b1; fs = 3'd6;
        tick();
        chk_out("force_bad_ignored", 0, 1, 0);
        fs = 3'd3;
        tick();
        chk_out("force_s3", 3, 1, 0);
        tick();
        chk_out("force_hold", 3, 1, 0);
        dwell = 8'd4;
        fv = 1'b0;
        tick();
        chk_out("force_release", 4, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("force_fresh_dwell%0d", i), 4, 1, 0);
        end
        tick();
        chk_out("force_after_dwell", 0, 1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
